ber_phase_scan: RTL

//  Scan controller for the Tx filter -> BER datapath. On i_start it enables Tx and Rx and steps
//  the phase selector through all N_PHASES. For each phase it settles, then counts BER errors over
//  a fixed window and keeps the phase with the fewest errors. It then locks the phase selector to

---
 rtl/ber_phase_scan_if.sv | 35 +++
 rtl/ber_phase_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ber_phase_scan_if.sv
// ---------------------------------------------------------------------------
// ber_phase_scan_if : control/status bundle between switch/VIO side and the
//                     phase-scan controller.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ber_phase_scan_if #(
  parameter int NB_PHASE   = 2,
  parameter int NB_ERR_CNT = 16
);
  logic                  start;
  logic                  stop;
  logic                  valid;
  logic                  err;
  logic                  en_tx;
  logic                  en_rx;
  logic [NB_PHASE-1:0]   phase_sel;
  logic                  busy;
  logic                  done;
  logic [NB_PHASE-1:0]   best_phase;
  logic [NB_ERR_CNT-1:0] best_err;
  logic                  rescan;

  modport master (
    output start, stop, valid, err,
    input  en_tx, en_rx, phase_sel, busy, done, best_phase, best_err, rescan
  );

  modport slave (
    input  start, stop, valid, err,
    output en_tx, en_rx, phase_sel, busy, done, best_phase, best_err, rescan
  );
endinterface

`default_nettype wire

// File: rtl/ber_phase_scan.sv
// ---------------------------------------------------------------------------
// ber_phase_scan : scans all sampling phases, measures BER per phase and
//                  locks onto the phase with the fewest errors.
// Optional macro AUTO_RESCAN_EN: rescan when a locked window exceeds RESCAN_THR.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ber_phase_scan #(
  parameter int N_PHASES    = 4,
  parameter int NB_PHASE    = 2,
  parameter int NB_ERR_CNT  = 16,
  parameter int SETTLE_SYMS = 16,
  parameter int WINDOW_SYMS = 511
`ifdef AUTO_RESCAN_EN
  , parameter int RESCAN_THR = 8
`endif
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ber_phase_scan_if.slave  bus
);

  localparam int NB_SET = $clog2(SETTLE_SYMS + 1);
  localparam int NB_WIN = $clog2(WINDOW_SYMS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  state_t                r_state;
  logic [NB_PHASE-1:0]   r_phase;
  logic [NB_PHASE-1:0]   r_best_phase;
  logic [NB_ERR_CNT-1:0] r_err_cnt;
  logic [NB_ERR_CNT-1:0] r_best_err;
  logic [NB_SET-1:0]     r_set_cnt;
  logic [NB_WIN-1:0]     r_sym_cnt;
  logic                  r_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_rescan;

  logic [NB_ERR_CNT-1:0] w_err_inc;
  logic                  w_win_end;
  logic                  w_better;
  logic                  w_auto_rescan;
  logic                  w_restart;

  always_comb begin
    w_err_inc = r_err_cnt;
    if (bus.err && (r_err_cnt != {NB_ERR_CNT{1'b1}}))
      w_err_inc = r_err_cnt + NB_ERR_CNT'(1);
    w_win_end     = bus.valid && (r_sym_cnt == NB_WIN'(WINDOW_SYMS - 1));
    w_better      = (r_err_cnt < r_best_err);
    w_auto_rescan = 1'b0;
`ifdef AUTO_RESCAN_EN
    w_auto_rescan = (r_state == S_LOCKED) && w_win_end &&
                    (w_err_inc > NB_ERR_CNT'(RESCAN_THR));
`endif
    // start is only honoured when no scan is running
    w_restart = (bus.start && ((r_state == S_IDLE) || (r_state == S_LOCKED))) ||
                w_auto_rescan;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_best_phase <= '0;
      r_err_cnt    <= '0;
      r_best_err   <= {NB_ERR_CNT{1'b1}};
      r_set_cnt    <= '0;
      r_sym_cnt    <= '0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rescan     <= 1'b0;
    end else begin
      r_rescan <= 1'b0;
      if (bus.stop) begin
        // best_* are deliberately kept so the last result stays observable
        r_state   <= S_IDLE;
        r_phase   <= '0;
        r_err_cnt <= '0;
        r_set_cnt <= '0;
        r_sym_cnt <= '0;
        r_en      <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
      end else if (w_restart) begin
        r_state      <= S_SETTLE;
        r_phase      <= '0;
        r_best_phase <= '0;
        r_best_err   <= {NB_ERR_CNT{1'b1}};
        r_err_cnt    <= '0;
        r_set_cnt    <= '0;
        r_sym_cnt    <= '0;
        r_en         <= 1'b1;
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_rescan     <= w_auto_rescan;
      end else begin
        case (r_state)
          S_SETTLE: begin
            if (bus.valid) begin
              if (r_set_cnt == NB_SET'(SETTLE_SYMS - 1)) begin
                r_state   <= S_MEASURE;
                r_set_cnt <= '0;
                r_err_cnt <= '0;
                r_sym_cnt <= '0;
              end else begin
                r_set_cnt <= r_set_cnt + NB_SET'(1);
              end
            end
          end
          S_MEASURE: begin
            if (bus.valid) begin
              r_err_cnt <= w_err_inc;
              if (w_win_end) begin
                r_state   <= S_COMPARE;
                r_sym_cnt <= '0;
              end else begin
                r_sym_cnt <= r_sym_cnt + NB_WIN'(1);
              end
            end
          end
          S_COMPARE: begin
            if (w_better) begin
              r_best_phase <= r_phase;
              r_best_err   <= r_err_cnt;
            end
            if (r_phase == NB_PHASE'(N_PHASES - 1)) begin
              r_state   <= S_LOCKED;
              r_phase   <= w_better ? r_phase : r_best_phase;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_err_cnt <= '0;
              r_sym_cnt <= '0;
            end else begin
              r_state   <= S_SETTLE;
              r_phase   <= r_phase + NB_PHASE'(1);
              r_set_cnt <= '0;
            end
          end
          S_LOCKED: begin
`ifdef AUTO_RESCAN_EN
            // window monitor; the over-threshold case is taken by w_restart
            if (bus.valid) begin
              if (w_win_end) begin
                r_err_cnt <= '0;
                r_sym_cnt <= '0;
              end else begin
                r_err_cnt <= w_err_inc;
                r_sym_cnt <= r_sym_cnt + NB_WIN'(1);
              end
            end
`endif
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.en_tx      = r_en;
  assign bus.en_rx      = r_en;
  assign bus.phase_sel  = r_phase;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.best_phase = r_best_phase;
  assign bus.best_err   = r_best_err;
  assign bus.rescan     = r_rescan;

endmodule

`default_nettype wire
